uart_rx_byte: RTL

Serial-to-byte UART receiver (8N1, LSB first) that sits directly upstream of the command-frame parser. It takes the raw RX pin from the board header and delivers each received byte with a one-cycle valid pulse. The parser consumes the rising edge of that pulse and the byte bus. Stop-bit violations are reported on a separate error strobe, and the bad byte is never presented as valid.

---
 rtl/uart_rx_byte.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
// Serial-to-byte UART receiver, 8N1, LSB first. It oversamples the raw RX pin
// against the system clock and samples each bit at its midpoint. Each correctly
// framed byte is presented with a one-cycle valid pulse.
//
// Ports:
//   i_Clk        system clock, all registers update on its rising edge
//   i_Rst_n      synchronous active-low reset
//   i_RX_Serial  raw asynchronous UART line, idle high
//   o_RX_DV      one-cycle pulse, o_RX_Byte valid while high
//   o_RX_Byte    last correctly framed byte, held between frames
//   o_Frame_Err  one-cycle pulse when the stop bit is sampled low
//   o_Busy       high in every state except IDLE
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_Frame_Err,
  output logic       o_Busy
);

  localparam int H  = (CLKS_PER_BIT - 1) / 2;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_CNT = CW'(H);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;

  logic cnt_clear;
  logic cnt_inc;
  logic idx_clear;
  logic idx_inc;
  logic sample_bit;
  logic dv_set;
  logic err_set;

  // Two-flop synchroniser. It resets to the idle level so that a reset never
  // looks like a start edge.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= i_RX_Serial;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!sync2) next_state = START;
      end
      START: begin
        // The line is checked again at half a bit so that short glitches are rejected.
        if (cnt >= HALF_CNT) next_state = sync2 ? IDLE : DATA;
      end
      DATA: begin
        if (cnt >= LAST_CNT && idx == 3'd7) next_state = STOP;
      end
      STOP: begin
        if (cnt >= LAST_CNT) next_state = sync2 ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        // A held-low line (break) must go idle before a new start is accepted.
        if (sync2) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_Busy     = 1'b1;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    idx_clear  = 1'b0;
    idx_inc    = 1'b0;
    sample_bit = 1'b0;
    dv_set     = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        o_Busy = 1'b0;
        if (!sync2) cnt_clear = 1'b1;
      end
      START: begin
        if (cnt < HALF_CNT) begin
          cnt_inc = 1'b1;
        end else if (!sync2) begin
          cnt_clear = 1'b1;
          idx_clear = 1'b1;
        end
      end
      DATA: begin
        if (cnt < LAST_CNT) begin
          cnt_inc = 1'b1;
        end else begin
          cnt_clear  = 1'b1;
          sample_bit = 1'b1;
          if (idx != 3'd7) idx_inc = 1'b1;
        end
      end
      STOP: begin
        if (cnt < LAST_CNT) begin
          cnt_inc = 1'b1;
        end else if (sync2) begin
          dv_set = 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end
      WAIT_HIGH: begin
      end
      default: begin
      end
    endcase
  end

  // Datapath. o_RX_Byte is loaded only together with the valid pulse, so a
  // badly framed byte never reaches the output.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      cnt         <= '0;
      idx         <= 3'd0;
      shift       <= 8'h00;
      o_RX_Byte   <= 8'h00;
      o_RX_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;
    end else begin
      o_RX_DV     <= dv_set;
      o_Frame_Err <= err_set;
      if (cnt_clear) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (idx_clear) begin
        idx <= 3'd0;
      end else if (idx_inc) begin
        idx <= idx + 3'd1;
      end
      if (sample_bit) shift[idx] <= sync2;
      if (dv_set) o_RX_Byte <= shift;
    end
  end

endmodule
